// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand selection.
// Define ID_EX_FORWARD_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module id_ex_operand_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Flush,
    input  logic [DW-1:0] IdBusA,
    input  logic [DW-1:0] IdBusB,
    input  logic [DW-1:0] IdImm,
    input  logic [4:0]    IdShamt,
    input  logic [RW-1:0] IdRs,
    input  logic [RW-1:0] IdRt,
    input  logic [RW-1:0] IdRd,
    input  logic          IdUseRs,
    input  logic          IdUseRt,
    input  logic [3:0]    IdALUCtrl,
    input  logic          IdALUSrc,
    input  logic          IdUseShamt,
    input  logic          IdRegDst,
    input  logic          IdRegWrite,
    input  logic          IdMemRead,
    input  logic          IdMemWrite,
    input  logic          IdMemToReg,
    input  logic          MemRegWrite,
    input  logic [RW-1:0] MemRw,
    input  logic [DW-1:0] MemALUOut,
    input  logic          WbRegWrite,
    input  logic [RW-1:0] WbRw,
    input  logic [DW-1:0] WbData,
    output logic          Stall,
    output logic [DW-1:0] BusA,
    output logic [DW-1:0] BusB,
    output logic [3:0]    ALUCtrl,
    output logic [RW-1:0] ExRw,
    output logic [DW-1:0] ExStoreData,
    output logic          ExRegWrite,
    output logic          ExMemRead,
    output logic          ExMemWrite,
    output logic          ExMemToReg
);

    typedef struct packed {
        logic [DW-1:0] bus_a;
        logic [DW-1:0] bus_b;
        logic [DW-1:0] imm;
        logic [4:0]    shamt;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rw;
        logic [3:0]    alu;
        logic          alu_src;
        logic          use_shamt;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
    } id_ex_t;

    id_ex_t id_pkt;
    id_ex_t ex_d;
    id_ex_t ex_q;

    logic          hit_ex;
    logic          raw;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    always_comb begin
        id_pkt            = '0;
        id_pkt.bus_a      = IdBusA;
        id_pkt.bus_b      = IdBusB;
        id_pkt.imm        = IdImm;
        id_pkt.shamt      = IdShamt;
        id_pkt.rs         = IdRs;
        id_pkt.rt         = IdRt;
        id_pkt.rw         = IdRegDst ? IdRd : IdRt;
        id_pkt.alu        = IdALUCtrl;
        id_pkt.alu_src    = IdALUSrc;
        id_pkt.use_shamt  = IdUseShamt;
        id_pkt.reg_write  = IdRegWrite;
        id_pkt.mem_read   = IdMemRead;
        id_pkt.mem_write  = IdMemWrite;
        id_pkt.mem_to_reg = IdMemToReg;
    end

    // ID instruction reads the register held in EX (r0 never hazards)
    always_comb begin
        hit_ex = (ex_q.rw != '0) &&
                 ((IdUseRs && (IdRs == ex_q.rw)) ||
                  (IdUseRt && (IdRt == ex_q.rw)));
    end

`ifdef ID_EX_FORWARD_EN

    function automatic logic [DW-1:0] fwd_sel(
        input logic [RW-1:0] r,
        input logic [DW-1:0] rf,
        input logic          mem_we,
        input logic [RW-1:0] mem_rw,
        input logic [DW-1:0] mem_val,
        input logic          wb_we,
        input logic [RW-1:0] wb_rw,
        input logic [DW-1:0] wb_val
    );
        logic [DW-1:0] v;
        v = rf;
        if (mem_we && (mem_rw != '0) && (mem_rw == r))
            v = mem_val;
        else if (wb_we && (wb_rw != '0) && (wb_rw == r))
            v = wb_val;
        return v;
    endfunction

    always_comb begin
        raw   = ex_q.mem_read & hit_ex;
        fwd_a = fwd_sel(ex_q.rs, ex_q.bus_a, MemRegWrite, MemRw,
                        MemALUOut, WbRegWrite, WbRw, WbData);
        fwd_b = fwd_sel(ex_q.rt, ex_q.bus_b, MemRegWrite, MemRw,
                        MemALUOut, WbRegWrite, WbRw, WbData);
    end

`else

    logic hit_mem;
    logic unused_sink;

    always_comb begin
        hit_mem = (MemRw != '0) &&
                  ((IdUseRs && (IdRs == MemRw)) ||
                   (IdUseRt && (IdRt == MemRw)));
    end

    // MEM/WB is covered by the write-first register file, so no stall for it
    always_comb begin
        raw = ((ex_q.reg_write | ex_q.mem_read) & hit_ex) |
              (MemRegWrite & hit_mem);
        fwd_a = ex_q.bus_a;
        fwd_b = ex_q.bus_b;
    end

    assign unused_sink = ^{MemALUOut, WbRegWrite, WbRw, WbData,
                           ex_q.rs, ex_q.rt};

`endif

    // a dead (flushed) ID instruction must not hold the front end
    assign Stall = ~Flush & raw;

    always_comb begin
        ex_d = id_pkt;
        if (Flush || Stall)
            ex_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (Reset)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign BusA        = ex_q.use_shamt ?
                         {{(DW-5){1'b0}}, ex_q.shamt} : fwd_a;
    assign BusB        = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign ExStoreData = fwd_b;
    assign ALUCtrl     = ex_q.alu;
    assign ExRw        = ex_q.rw;
    assign ExRegWrite  = ex_q.reg_write;
    assign ExMemRead   = ex_q.mem_read;
    assign ExMemWrite  = ex_q.mem_write;
    assign ExMemToReg  = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage; expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_operand_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          CLK = 1'b0;
    logic          Reset, Flush;
    logic [DW-1:0] IdBusA, IdBusB, IdImm;
    logic [4:0]    IdShamt;
    logic [RW-1:0] IdRs, IdRt, IdRd;
    logic          IdUseRs, IdUseRt;
    logic [3:0]    IdALUCtrl;
    logic          IdALUSrc, IdUseShamt, IdRegDst;
    logic          IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
    logic          MemRegWrite;
    logic [RW-1:0] MemRw;
    logic [DW-1:0] MemALUOut;
    logic          WbRegWrite;
    logic [RW-1:0] WbRw;
    logic [DW-1:0] WbData;
    logic          Stall;
    logic [DW-1:0] BusA, BusB, ExStoreData;
    logic [3:0]    ALUCtrl;
    logic [RW-1:0] ExRw;
    logic          ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg;

    always #5 CLK = ~CLK;

    id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .CLK(CLK), .Reset(Reset), .Flush(Flush),
        .IdBusA(IdBusA), .IdBusB(IdBusB), .IdImm(IdImm),
        .IdShamt(IdShamt), .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd),
        .IdUseRs(IdUseRs), .IdUseRt(IdUseRt), .IdALUCtrl(IdALUCtrl),
        .IdALUSrc(IdALUSrc), .IdUseShamt(IdUseShamt),
        .IdRegDst(IdRegDst), .IdRegWrite(IdRegWrite),
        .IdMemRead(IdMemRead), .IdMemWrite(IdMemWrite),
        .IdMemToReg(IdMemToReg), .MemRegWrite(MemRegWrite),
        .MemRw(MemRw), .MemALUOut(MemALUOut),
        .WbRegWrite(WbRegWrite), .WbRw(WbRw), .WbData(WbData),
        .Stall(Stall), .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl),
        .ExRw(ExRw), .ExStoreData(ExStoreData),
        .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
        .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg)
    );

    typedef struct packed {
        logic [4:0]  rs, rt, rd;
        logic        urs, urt;
        logic [31:0] a, b, imm;
        logic [4:0]  sh;
        logic [3:0]  alu;
        logic        src, ush, dst, rw, mr, mw, m2r;
    } ins_t;

    typedef struct {
        string       nm;
        logic [5:0]  m;
        logic        s;
        logic [31:0] a, b, d;
        logic [3:0]  alu;
        logic [4:0]  rw;
        logic [3:0]  ctl;
    } exp_t;

    localparam logic [5:0] MS = 6'b100000;
    localparam logic [5:0] MA = 6'b010000;
    localparam logic [5:0] MB = 6'b001000;
    localparam logic [5:0] MD = 6'b000100;
    localparam logic [5:0] MK = 6'b000010;
    localparam logic [5:0] MC = 6'b000001;
    localparam logic [5:0] ALL = 6'b111111;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic ins_t rtype(input logic [4:0] rs, rt, rd,
                                   input logic [31:0] a, b,
                                   input logic [3:0] alu);
        ins_t i;
        i = '0;
        i.rs = rs; i.rt = rt; i.rd = rd;
        i.urs = 1'b1; i.urt = 1'b1;
        i.a = a; i.b = b; i.alu = alu;
        i.dst = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input logic [4:0] rs, rt,
                                input logic [31:0] a);
        ins_t i;
        i = '0;
        i.rs = rs; i.rt = rt; i.urs = 1'b1;
        i.a = a; i.src = 1'b1; i.alu = 4'b0010;
        i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1;
        return i;
    endfunction

    task automatic drive(input ins_t i);
        IdRs = i.rs; IdRt = i.rt; IdRd = i.rd;
        IdUseRs = i.urs; IdUseRt = i.urt;
        IdBusA = i.a; IdBusB = i.b; IdImm = i.imm;
        IdShamt = i.sh; IdALUCtrl = i.alu;
        IdALUSrc = i.src; IdUseShamt = i.ush; IdRegDst = i.dst;
        IdRegWrite = i.rw; IdMemRead = i.mr;
        IdMemWrite = i.mw; IdMemToReg = i.m2r;
    endtask

    task automatic side(input logic mwe, input logic [4:0] mrw,
                        input logic [31:0] mv, input logic wwe,
                        input logic [4:0] wrw, input logic [31:0] wv);
        MemRegWrite = mwe; MemRw = mrw; MemALUOut = mv;
        WbRegWrite = wwe; WbRw = wrw; WbData = wv;
    endtask

    task automatic push(input string nm, input logic [5:0] m,
                        input logic s, input logic [31:0] a, b, d,
                        input logic [3:0] alu, input logic [4:0] rw,
                        input logic [3:0] ctl);
        exp_t e;
        e.nm = nm; e.m = m; e.s = s;
        e.a = a; e.b = b; e.d = d;
        e.alu = alu; e.rw = rw; e.ctl = ctl;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] want);
        n_run++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, want %0h", nm, f, act, want);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.m[5]) cmp(e.nm, "Stall", {31'b0, Stall}, {31'b0, e.s});
            if (e.m[4]) cmp(e.nm, "BusA", BusA, e.a);
            if (e.m[3]) cmp(e.nm, "BusB", BusB, e.b);
            if (e.m[2]) cmp(e.nm, "StoreData", ExStoreData, e.d);
            if (e.m[1]) begin
                cmp(e.nm, "ALUCtrl", {28'b0, ALUCtrl}, {28'b0, e.alu});
                cmp(e.nm, "ExRw", {27'b0, ExRw}, {27'b0, e.rw});
            end
            if (e.m[0])
                cmp(e.nm, "ctl",
                    {28'b0, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg},
                    {28'b0, e.ctl});
        end
    end

    initial begin
        ins_t        nop, i;
        logic [159:0] rnd;
        nop = '0;

        // reset with random ID inputs
        Reset = 1'b1; Flush = 1'b0;
        side(0, 0, 0, 0, 0, 0);
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drive(ins_t'(rnd[$bits(ins_t)-1:0]));
        tick();
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        drive(ins_t'(rnd[$bits(ins_t)-1:0]));
        push("reset1", ALL, 0, 0, 0, 0, 0, 0, 0);
        tick();
        Reset = 1'b0; drive(nop);
        push("reset2", ALL, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // sll then lui
        i = rtype(0, 3, 2, 32'h99, 32'h30, 4'h3);
        i.urs = 1'b0; i.ush = 1'b1; i.sh = 5'd4;
        drive(i);
        push("sll_id", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        i = '0;
        i.rt = 5; i.urt = 1'b0; i.src = 1'b1; i.imm = 32'h1234;
        i.b = 32'h77; i.rw = 1'b1; i.alu = 4'hE;
        drive(i);
        push("sll_ex", ALL, 0, 32'h4, 32'h30, 32'h30, 4'h3, 5'd2, 4'b1000);
        tick();
        drive(nop);
        push("lui_ex", ALL, 0, 0, 32'h1234, 32'h77, 4'hE, 5'd5, 4'b1000);
        tick();

        // flush coincident with load-use
        drive(lw(1, 5, 32'h100));
        push("ld_id", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(rtype(5, 2, 6, 0, 2, 4'h2)); Flush = 1'b1;
        push("flush_ld", MS | MK | MC, 0, 0, 0, 0, 4'h2, 5'd5, 4'b1101);
        tick();
        Flush = 1'b0; drive(nop);
        push("flush_bub", MS | MC, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // mid-stream reset
        drive(rtype(1, 2, 3, 32'h5, 32'h7, 4'h2));
        push("pre_add", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        Reset = 1'b1; drive(nop);
        push("pre_rst", MK | MC, 0, 0, 0, 0, 4'h2, 5'd3, 4'b1000);
        tick();
        Reset = 1'b0;
        push("mid_rst", ALL, 0, 0, 0, 0, 0, 0, 0);
        tick();

`ifdef ID_EX_FORWARD_EN
        drive(rtype(3, 1, 4, 32'h33, 32'h5, 4'h6));
        push("sub_id", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(nop); side(1, 3, 32'd12, 0, 0, 0);
        push("fwd_mem", ALL, 0, 32'd12, 32'h5, 32'h5, 4'h6, 5'd4, 4'b1000);
        tick();
        side(0, 0, 0, 0, 0, 0);
        drive(rtype(7, 0, 8, 32'h11, 32'h22, 4'h2));
        tick();
        drive(nop); side(1, 7, 32'hAAAA, 1, 7, 32'hBBBB);
        push("fwd_prio", MA, 0, 32'hAAAA, 0, 0, 0, 0, 0);
        tick();
        side(0, 0, 0, 0, 0, 0);
        drive(rtype(7, 0, 8, 32'h11, 32'h22, 4'h2));
        tick();
        drive(nop); side(0, 0, 0, 1, 7, 32'hBBBB);
        push("fwd_wb", MA, 0, 32'hBBBB, 0, 0, 0, 0, 0);
        tick();
        side(0, 0, 0, 0, 0, 0);
        drive(rtype(0, 0, 8, 32'h11, 32'h22, 4'h2));
        tick();
        drive(nop); side(1, 0, 32'hAAAA, 1, 0, 32'hBBBB);
        push("fwd_r0", MA | MB, 0, 32'h11, 32'h22, 0, 0, 0, 0);
        tick();
        side(0, 0, 0, 0, 0, 0);
        drive(rtype(1, 2, 3, 32'h1, 32'h2, 4'h2));
        tick();
        drive(rtype(3, 1, 4, 32'h3, 32'h1, 4'h2));
        push("no_raw_stall", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(lw(1, 5, 32'h100));
        push("ld_id2", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(rtype(5, 2, 6, 0, 32'h2, 4'h2));
        push("ldu_stall", MS | MK | MC, 1, 0, 0, 0, 4'h2, 5'd5, 4'b1101);
        tick();
        side(1, 5, 32'h100, 0, 0, 0);
        push("ldu_bub", MS | MC, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(nop); side(0, 0, 0, 1, 5, 32'hD00D);
        push("ldu_fwd", MS | MA | MB | MK | MC, 0, 32'hD00D, 32'h2, 0,
             4'h2, 5'd6, 4'b1000);
        tick();
        side(0, 0, 0, 0, 0, 0);
`else
        drive(rtype(3, 1, 4, 32'h33, 32'h5, 4'h6));
        push("sub_id", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(nop); side(1, 3, 32'd12, 1, 1, 32'hBBBB);
        push("no_fwd", ALL, 0, 32'h33, 32'h5, 32'h5, 4'h6, 5'd4, 4'b1000);
        tick();
        side(0, 0, 0, 0, 0, 0);
        drive(rtype(1, 2, 3, 32'h1, 32'h2, 4'h2));
        push("add1_id", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(rtype(3, 1, 4, 32'h30, 32'h10, 4'h2));
        push("raw_ex", MS | MK | MC, 1, 0, 0, 0, 4'h2, 5'd3, 4'b1000);
        tick();
        side(1, 3, 0, 0, 0, 0);
        push("raw_mem", MS | MC, 1, 0, 0, 0, 0, 0, 0);
        tick();
        side(0, 0, 0, 1, 3, 0);
        push("raw_wb", MS | MC, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(nop); side(0, 0, 0, 0, 0, 0);
        push("raw_in", MS | MA | MK | MC, 0, 32'h30, 0, 0,
             4'h2, 5'd4, 4'b1000);
        tick();
        i = rtype(4, 4, 6, 0, 0, 4'h2);
        i.urs = 1'b0; i.urt = 1'b0;
        drive(i);
        push("use_gate", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(rtype(1, 2, 0, 0, 0, 4'h2));
        tick();
        drive(rtype(0, 0, 7, 0, 0, 4'h2));
        push("r0_nostall", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(lw(1, 5, 32'h100));
        push("ld_id2", MS, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(rtype(2, 5, 6, 0, 32'h55, 4'h2));
        push("ldu_ex", MS | MK | MC, 1, 0, 0, 0, 4'h2, 5'd5, 4'b1101);
        tick();
        side(1, 5, 32'h100, 0, 0, 0);
        push("ldu_mem", MS | MC, 1, 0, 0, 0, 0, 0, 0);
        tick();
        side(0, 0, 0, 1, 5, 32'hD00D);
        push("ldu_wb", MS | MC, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(nop); side(0, 0, 0, 0, 0, 0);
        push("ldu_in", MS | MB | MK | MC, 0, 0, 32'h55, 0,
             4'h2, 5'd6, 4'b1000);
        tick();
`endif

        for (int k = 0; k < 8 && q.size() != 0; k++)
            @(posedge CLK);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
